// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: edge-detects left/right buttons, queues one relative turn, applies it on tick.
// Optional auto-repeat of a held button is compiled in with `define AUTO_REPEAT_EN.
module snake_dir_ctrl #(
  parameter logic [1:0] INIT_DIR   = 2'b01,
  parameter int         REPEAT_CYC = 25000000,
  parameter int         REPEAT_W   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       tick,
  input  logic       enable,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       pend_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND_L = 2'd1,
    PEND_R = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_dir;
  logic [1:0] w_dir_nxt;
  logic       r_dir_chg;
  logic       w_dir_chg_nxt;
  logic       r_prev_l;
  logic       r_prev_r;
  logic       w_rise_l;
  logic       w_rise_r;

  if (REPEAT_CYC < 2 || (REPEAT_CYC - 1) >= (1 << REPEAT_W)) begin : g_bad_param
    $error("snake_dir_ctrl: REPEAT_CYC must be >= 2 and fit in REPEAT_W bits");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_l <= 1'b0;
      r_prev_r <= 1'b0;
    end else begin
      r_prev_l <= btn_l;
      r_prev_r <= btn_r;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [REPEAT_W-1:0] REP_MAX = REPEAT_W'(REPEAT_CYC - 1);

  logic [REPEAT_W-1:0] r_rep_cnt;
  logic                r_syn_l;
  logic                r_syn_r;
  logic                w_one_held;

  assign w_one_held = enable & (btn_l ^ btn_r);
  assign w_rise_l   = (btn_l & ~r_prev_l) | r_syn_l;
  assign w_rise_r   = (btn_r & ~r_prev_r) | r_syn_r;

  // Any rise of the held button (real or synthetic) restarts the repeat period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
      r_syn_l   <= 1'b0;
      r_syn_r   <= 1'b0;
    end else begin
      r_syn_l <= 1'b0;
      r_syn_r <= 1'b0;
      if (!w_one_held || (btn_l & w_rise_l) || (btn_r & w_rise_r)) begin
        r_rep_cnt <= '0;
      end else if (r_rep_cnt == REP_MAX) begin
        r_rep_cnt <= '0;
        r_syn_l   <= btn_l;
        r_syn_r   <= btn_r;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  assign w_rise_l = btn_l & ~r_prev_l;
  assign w_rise_r = btn_r & ~r_prev_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dir     <= INIT_DIR;
      r_dir_chg <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_dir_chg <= w_dir_chg_nxt;
    end
  end

  // A tick consumes the old turn first; a rise on the same edge then queues for the next tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_dir_chg_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      if (tick && (r_state != IDLE)) begin
        w_dir_nxt     = (r_state == PEND_L) ? (r_dir - 2'd1) : (r_dir + 2'd1);
        w_dir_chg_nxt = 1'b1;
        w_state_nxt   = IDLE;
      end
      if (w_rise_l && !w_rise_r) begin
        w_state_nxt = PEND_L;
      end else if (w_rise_r && !w_rise_l) begin
        w_state_nxt = PEND_R;
      end
    end
  end

  assign dir         = r_dir;
  assign dir_changed = r_dir_chg;
  assign pend_valid  = (r_state != IDLE);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: directed scenarios then random stimulus vs. a turn-level model.
module tb_snake_dir_ctrl;

  localparam int REPEAT_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] dir;
  logic       dir_changed;
  logic       pend_valid;

  snake_dir_ctrl #(
    .INIT_DIR  (2'b01),
    .REPEAT_CYC(REPEAT_CYC),
    .REPEAT_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .tick       (tick),
    .enable     (enable),
    .dir        (dir),
    .dir_changed(dir_changed),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dc_seen = 0;
  bit started = 1'b0;

  logic [3:0] exp_q[$];
  logic [1:0] turn_q[$];

  // Model: heading as integer, queued turn as -1/0/+1, repeat tracked as edges since last rise.
  int m_dir, m_pend, m_age, m_syn;
  bit m_pl, m_pr;

  task automatic model_reset();
    m_dir  = 1;
    m_pend = 0;
    m_age  = 0;
    m_syn  = 0;
    m_pl   = 1'b0;
    m_pr   = 1'b0;
  endtask

  task automatic model_step(input bit bl, input bit br, input bit tk, input bit en);
    bit rl, rr, dc;
    rl = bl && !m_pl;
    rr = br && !m_pr;
`ifdef AUTO_REPEAT_EN
    if (m_syn < 0) rl = 1'b1;
    if (m_syn > 0) rr = 1'b1;
    m_syn = 0;
    if (en && (bl != br)) begin
      if ((bl && rl) || (br && rr)) m_age = 0;
      else begin
        m_age++;
        if (m_age == REPEAT_CYC) begin
          m_age = 0;
          m_syn = bl ? -1 : 1;
        end
      end
    end else begin
      m_age = 0;
    end
`endif
    dc = 1'b0;
    if (!en) begin
      m_pend = 0;
    end else begin
      if (tk && m_pend != 0) begin
        m_dir  = (m_dir + m_pend + 4) % 4;
        m_pend = 0;
        dc     = 1'b1;
        turn_q.push_back(2'(m_dir));
      end
      if (rl && !rr) m_pend = -1;
      else if (rr && !rl) m_pend = 1;
    end
    m_pl = bl;
    m_pr = br;
    exp_q.push_back({2'(m_dir), (m_pend != 0), dc});
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; returns just after the following posedge so outputs can be sampled.
  task automatic cyc(input bit bl, input bit br, input bit tk, input bit en);
    @(negedge clk);
    rst_n  = 1'b1;
    btn_l  = bl;
    btn_r  = br;
    tick   = tk;
    enable = en;
    model_step(bl, br, tk, en);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_dir", int'(dir), 1);
    chk("reset_pend_valid", int'(pend_valid), 0);
    chk("reset_dir_changed", int'(dir_changed), 0);
    model_reset();
    exp_q.push_back({2'b01, 1'b0, 1'b0});
    started = 1'b1;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    logic [3:0] e;
    logic [1:0] t;
    #1;
    if (started) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: DUT cycle with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({dir, pend_valid, dir_changed} !== e) begin
          n_bad++;
          $display("FAIL cycle_outputs: got dir=%b pend=%b chg=%b, expected dir=%b pend=%b chg=%b at %0t",
                   dir, pend_valid, dir_changed, e[3:2], e[1], e[0], $time);
        end
      end
      if (dir_changed === 1'b1) begin
        n_dc_seen++;
        n_cmp++;
        if (turn_q.size() == 0) begin
          n_bad++;
          $display("FAIL turn_unexpected: dir_changed with dir=%b but no turn expected at %0t", dir, $time);
        end else begin
          t = turn_q.pop_front();
          if (dir !== t) begin
            n_bad++;
            $display("FAIL turn_dir: got %b, expected %b at %0t", dir, t, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_turns;
    bit bl, br;
    logic [1:0] seq3[4];
    seq3[0] = 2'b00; seq3[1] = 2'b11; seq3[2] = 2'b10; seq3[3] = 2'b01;
    model_reset();
    do_reset();

    // Reset mid-run with a right turn queued.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("t1_pend_before_reset", int'(pend_valid), 1);
    do_reset();
    cyc(0, 0, 0, 1);

    // Right press, tick three cycles later.
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    chk("t2_dir", int'(dir), 2);
    chk("t2_changed", int'(dir_changed), 1);
    chk("t2_pend", int'(pend_valid), 0);
    cyc(0, 0, 0, 1);
    chk("t2_changed_one_cycle", int'(dir_changed), 0);

    // Four left turns wrap through 00 and 11.
    do_reset();
    base = n_dc_seen;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1);
      cyc(0, 0, 1, 1);
      chk("t3_dir", int'(dir), int'(seq3[i]));
      cyc(0, 0, 0, 1);
    end
    chk("t3_pulses", n_dc_seen - base, 4);

    // Simultaneous rise ignored; newest press overwrites.
    cyc(1, 1, 0, 1);
    chk("t4_both_ignored", int'(pend_valid), 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    chk("t4_overwrite_dir", int'(dir), 2);

    // Tick and new rise on the same edge, then pause behaviour.
    cyc(1, 0, 0, 1);
    cyc(0, 1, 1, 1);
    chk("t5_left_applied", int'(dir), 1);
    chk("t5_right_queued", int'(pend_valid), 1);
    cyc(0, 0, 1, 1);
    chk("t5_right_applied", int'(dir), 2);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t5_pause_clears", int'(pend_valid), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("t5_pause_dir", int'(dir), 2);
    cyc(0, 0, 0, 1);

    // Held right button with a tick every cycle.
    do_reset();
    base = n_dc_seen;
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
`ifdef AUTO_REPEAT_EN
    exp_turns = 3;
`else
    exp_turns = 1;
`endif
    chk("t6_hold_turns", n_dc_seen - base, exp_turns);

    // Random traffic against the model.
    bl = 1'b0;
    br = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 5) == 0) bl = ~bl;
        if ($urandom_range(0, 5) == 0) br = ~br;
        cyc(bl, br, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) != 0));
      end
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    chk("queue_drained_exp", exp_q.size(), 0);
    chk("queue_drained_turn", turn_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
